// File: rtl/cdr_mm_gearshift.sv
// cdr_mm_gearshift: baud-rate Mueller-Muller CDR with PI loop, phase-wrap DCO, lock FSM and gear shifting
// Ports: clk/rst (sync, active high), y_n sample in, loop_en closes the loop;
//        sample_en symbol strobe, x_n/d_bb sample and decision, f_n phase error,
//        v_ctrl loop filter, dfcw clamped trim, lock/state tracking status.
module cdr_mm_gearshift #(
  parameter int W = 8,
  parameter int PHASE_BITS = 32,
  parameter logic [PHASE_BITS-1:0] FCW_NOM = PHASE_BITS'(1) << (PHASE_BITS - 1),
  parameter int KP_ACQ_SHIFT = 10,
  parameter int KI_ACQ_SHIFT = 16,
  parameter int KP_TRK_SHIFT = 12,
  parameter int KI_TRK_SHIFT = 18,
  parameter int DFCW_SHIFT = 8,
  parameter logic [31:0] DFCW_CLAMP = 32'(FCW_NOM >> 10),
  parameter int LOCK_THRESH = 8,
  parameter int LOCK_WIN = 32,
  parameter int LOSS_WIN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [W-1:0]   y_n,
  input  logic                  loop_en,
  output logic                  sample_en,
  output logic signed [W-1:0]   x_n,
  output logic                  d_bb,
  output logic signed [2*W-1:0] f_n,
  output logic signed [31:0]    v_ctrl,
  output logic signed [31:0]    dfcw,
  output logic                  lock,
  output logic [1:0]            state
);
  localparam logic [1:0] ACQ = 2'd0;
  localparam logic [1:0] TRK = 2'd1;
  localparam int CW = $clog2((LOCK_WIN > LOSS_WIN ? LOCK_WIN : LOSS_WIN) + 1);
  localparam logic signed [31:0] LIM = DFCW_CLAMP;
  logic [PHASE_BITS-1:0] r_phase, w_nxt;
  logic signed [W-1:0] r_x_n, r_x_z1;
  logic r_d_z1, r_lock;
  logic signed [31:0] r_acc, r_v;
  logic [CW-1:0] r_good_cnt, r_bad_cnt;
  logic [1:0] r_state;
  logic signed [2*W-1:0] w_t1, w_t2;
  logic signed [31:0] w_fx, w_p, w_i, w_du;
  logic signed [32:0] w_pi;
  logic w_trk, w_good, w_hi, w_lo, w_f_pos, w_f_neg, w_run, w_acc_upd, w_v_upd;
  function automatic logic signed [31:0] sat(input logic signed [33:0] x);
    return (x > 34'sh07FFFFFFF) ? 32'sh7FFFFFFF : (x < -34'sh080000000) ? 32'sh80000000 : x[31:0];
  endfunction
  assign w_nxt     = r_phase + FCW_NOM + PHASE_BITS'(dfcw);
  assign sample_en = w_nxt < r_phase;
  assign x_n       = r_x_n;
  assign d_bb      = ~r_x_n[W-1];
  assign w_t1      = d_bb ? (2*W)'(r_x_z1) : -(2*W)'(r_x_z1);
  assign w_t2      = r_d_z1 ? (2*W)'(r_x_n) : -(2*W)'(r_x_n);
  assign f_n       = w_t1 - w_t2;
  assign w_good    = (f_n[2*W-1] ? -f_n : f_n) <= (2*W)'(LOCK_THRESH);
  assign w_trk     = r_state == TRK;
  assign w_fx      = 32'(f_n);
  assign w_p       = w_trk ? w_fx >>> KP_TRK_SHIFT : w_fx >>> KP_ACQ_SHIFT;
  assign w_i       = w_trk ? r_acc >>> KI_TRK_SHIFT : r_acc >>> KI_ACQ_SHIFT;
  assign w_pi      = 33'(w_p) + 33'(w_i);
  assign w_du      = r_v >>> DFCW_SHIFT;
  assign w_hi      = w_du > LIM;
  assign w_lo      = w_du < -LIM;
  assign dfcw      = w_hi ? LIM : w_lo ? -LIM : w_du;
  assign w_f_pos   = !f_n[2*W-1] && (f_n != '0);
  assign w_f_neg   = f_n[2*W-1];
  assign w_run     = sample_en && loop_en;
  // while clamped, only updates that pull back toward the usable range are allowed
  assign w_acc_upd = w_run && !(w_hi && w_f_pos) && !(w_lo && w_f_neg);
  assign w_v_upd   = w_run && !(w_hi && !w_pi[32] && (w_pi != '0)) && !(w_lo && w_pi[32]);
  assign v_ctrl    = r_v;
  assign lock      = r_lock;
  assign state     = r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase    <= '0;
      r_x_n      <= '0;
      r_x_z1     <= '0;
      r_d_z1     <= 1'b0;
      r_acc      <= '0;
      r_v        <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_state    <= ACQ;
      r_lock     <= 1'b0;
    end else begin
      r_phase <= w_nxt;
      if (sample_en) begin
        r_x_n  <= y_n;
        r_x_z1 <= r_x_n;
        r_d_z1 <= d_bb;
      end
      if (w_acc_upd) r_acc <= sat(34'(r_acc) + 34'(w_fx));
      if (w_v_upd) r_v <= sat(34'(r_v) + 34'(w_pi));
      if (sample_en) begin
        if (!loop_en) begin
          r_state    <= ACQ;
          r_lock     <= 1'b0;
          r_good_cnt <= '0;
          r_bad_cnt  <= '0;
        end else if (!w_trk) begin
          if (!w_good) r_good_cnt <= '0;
          else if (r_good_cnt == CW'(LOCK_WIN - 1)) begin
            r_state    <= TRK;
            r_lock     <= 1'b1;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
          end else r_good_cnt <= r_good_cnt + 1'b1;
        end else begin
          if (w_good) r_bad_cnt <= '0;
          else if (r_bad_cnt == CW'(LOSS_WIN - 1)) begin
            r_state    <= ACQ;
            r_lock     <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
          end else r_bad_cnt <= r_bad_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdr_mm_gearshift.sv
// tb_cdr_mm_gearshift: directed self-checking bench for cdr_mm_gearshift
module tb_cdr_mm_gearshift;
  logic clk, rst, loop_en, sample_en, d_bb, lock;
  logic signed [7:0] y_n, x_n;
  logic signed [15:0] f_n, f_pre;
  logic signed [31:0] v_ctrl, dfcw, prev_dfcw;
  logic [1:0] state;
  logic signed [7:0] pat [4] = '{8'sd10, -8'sd100, -8'sd10, 8'sd100};
  int checks = 0;
  int errors = 0;

  cdr_mm_gearshift #(
    .KP_ACQ_SHIFT(2), .KI_ACQ_SHIFT(4), .KP_TRK_SHIFT(3), .KI_TRK_SHIFT(5),
    .DFCW_SHIFT(2), .DFCW_CLAMP(32'd64)
  ) dut (
    .clk(clk), .rst(rst), .y_n(y_n), .loop_en(loop_en), .sample_en(sample_en),
    .x_n(x_n), .d_bb(d_bb), .f_n(f_n), .v_ctrl(v_ctrl), .dfcw(dfcw),
    .lock(lock), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [33:0] obs, input logic signed [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic signed [7:0] y);
    int n;
    n = 0;
    y_n = y;
    @(negedge clk);
    while (!sample_en && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", sample_en, 1);
    f_pre = f_n;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_se"}, sample_en, 0);
    chk({tag, "_x"}, x_n, 0);
    chk({tag, "_d"}, d_bb, 1);
    chk({tag, "_f"}, f_n, 0);
    chk({tag, "_v"}, v_ctrl, 0);
    chk({tag, "_dfcw"}, dfcw, 0);
    chk({tag, "_lock"}, lock, 0);
    chk({tag, "_state"}, state, 0);
  endtask

  task automatic acquire();
    for (int k = 1; k <= 34; k++) begin
      strobe(64);
      if (k == 1) chk("acq_f1", f_pre, 0);
      if (k == 2) begin
        chk("acq_f2", f_pre, -64);
        chk("acq_v2", v_ctrl, -16);
      end
      if (k == 3) begin
        chk("acq_f3", f_pre, 0);
        chk("acq_v3", v_ctrl, -20);
      end
      if (k == 33) chk("acq_state33", state, 0);
    end
    chk("acq_lock34", lock, 1);
    chk("acq_state34", state, 1);
    chk("acq_v34", v_ctrl, -144);
    chk("acq_dfcw34", dfcw, -36);
    chk("acq_x", x_n, 64);
    chk("acq_d", d_bb, 1);
    strobe(64);
    chk("trk_gain_v35", v_ctrl, -146);
    chk("trk_state35", state, 1);
  endtask

  initial begin
    rst = 1'b1;
    loop_en = 1'b1;
    y_n = '0;
    f_pre = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_se_c2", sample_en, 1);
    @(posedge clk);
    #1;
    chk("t1_se_c3", sample_en, 0);
    @(posedge clk);
    #1;
    chk("t1_se_c4", sample_en, 1);
    repeat (5) strobe(0);
    chk("t1_f", f_pre, 0);
    chk("t1_v", v_ctrl, 0);
    chk("t1_dfcw", dfcw, 0);
    chk("t1_se_after", sample_en, 0);
    @(posedge clk);
    #1;
    chk("t1_se_period", sample_en, 1);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    acquire();

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("rst_mid");
    acquire();

    loop_en = 1'b0;
    strobe(64);
    chk("hold_state", state, 0);
    chk("hold_lock", lock, 0);
    chk("hold_v", v_ctrl, -146);
    chk("hold_dfcw", dfcw, -37);
    repeat (3) strobe(64);
    chk("hold_v_later", v_ctrl, -146);
    chk("hold_dfcw_later", dfcw, -37);
    loop_en = 1'b1;
    strobe(64);
    chk("resume_v", v_ctrl, -150);
    chk("resume_state", state, 0);
    for (int j = 2; j <= 32; j++) begin
      strobe(64);
      if (j == 31) chk("relock_state31", state, 0);
    end
    chk("relock_state", state, 1);
    chk("relock_v_clamped", v_ctrl, -258);
    chk("relock_dfcw", dfcw, -64);

    prev_dfcw = dfcw;
    for (int n = 0; n < 24; n++) begin
      strobe(pat[n % 4]);
      chk("pat_f", f_pre, (n == 0) ? 0 : (n == 1) ? 54 : 90);
      chk("pat_dfcw_mono", (dfcw >= prev_dfcw) ? 1 : 0, 1);
      prev_dfcw = dfcw;
      if (n == 7) chk("loss_state7", state, 1);
      if (n == 8) begin
        chk("loss_state8", state, 0);
        chk("loss_lock8", lock, 0);
        chk("loss_v8", v_ctrl, -124);
      end
      if (n == 9) chk("acq_gain_v9", v_ctrl, -64);
      if (n == 13) chk("pat_v13", v_ctrl, 234);
    end
    chk("clamp_v_frozen", v_ctrl, 322);
    chk("clamp_dfcw", dfcw, 64);
    chk("clamp_lock", lock, 0);
    chk("clamp_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
